// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the memory-mapped bus initiator: response codes,
// FSM state encoding and the stall-counter width helper.
package bus_initiator_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bits needed to count up to limit, never less than one.
    function automatic int cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_initiator.sv
// Single-transfer memory-mapped bus initiator: accepts one command, runs it on
// the bus with an optional stall timeout, and holds the result until consumed.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        rsp_timeout,
    output logic [31:0] bus_addr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic [31:0] bus_readdata,
    input  logic [1:0]  bus_response,
    input  logic        bus_waitrequest,
    output state_e      dbg_state
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    // Value of the stall counter during the cycle that would hit the limit.
    localparam logic [CW-1:0] LAST_STALL =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    // Handshakes: a beat transfers on the rising edge where valid & ready are
    // both high; valid never waits on ready and the payload is held while valid.
    state_e         state_q, state_d;
    logic           write_q;
    logic [31:0]    addr_q, wdata_q, rdata_q;
    logic [3:0]     be_q;
    logic [1:0]     status_q;
    logic           timeout_q;
    logic [CW-1:0]  stall_q;
    logic           accept, complete, expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        expire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                bus_read  = !write_q;
                bus_write = write_q;
                // Completion takes priority over a timeout landing in the same cycle.
                if (!bus_waitrequest) begin
                    complete = 1'b1;
                    state_d  = ST_RESP;
                end else if (TMO_EN && (stall_q == LAST_STALL)) begin
                    expire  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            stall_q   <= '0;
            rdata_q   <= '0;
            status_q  <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                be_q    <= cmd_be;
                stall_q <= '0;
            end else if (state_q == ST_BUS && bus_waitrequest && TMO_EN && !expire) begin
                stall_q <= stall_q + CW'(1);
            end
            if (complete) begin
                rdata_q   <= write_q ? 32'h0 : bus_readdata;
                status_q  <= bus_response;
                timeout_q <= 1'b0;
            end else if (expire) begin
                rdata_q   <= 32'h0;
                status_q  <= RESP_DECERR;
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus_addr       = addr_q;
    assign bus_writedata  = wdata_q;
    assign bus_byteenable = be_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_status     = status_q;
    assign rsp_timeout    = timeout_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: one instance with a short timeout and one
// with the timeout disabled, responses checked through an expected queue.
module tb_bus_initiator;
    import bus_initiator_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] bus_readdata = '0;
    logic [1:0]  bus_response = '0;
    logic        bus_waitrequest = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_timeout, bus_read, bus_write;
    logic [31:0] rsp_rdata, bus_addr, bus_writedata;
    logic [1:0]  rsp_status;
    logic [3:0]  bus_byteenable;
    state_e      dbg_state;

    logic        nt_cmd_valid = 1'b0, nt_rsp_ready = 1'b0, nt_waitrequest = 1'b0;
    logic        nt_cmd_ready, nt_rsp_valid, nt_rsp_timeout, nt_bus_read, nt_bus_write;
    logic [31:0] nt_rsp_rdata, nt_bus_addr, nt_bus_writedata;
    logic [1:0]  nt_rsp_status;
    logic [3:0]  nt_bus_byteenable;
    state_e      nt_dbg_state;

    int errors = 0;
    int checks = 0;
    logic [34:0] exp_q[$];
    logic [34:0] last_exp;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
        .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
        .bus_readdata(bus_readdata), .bus_response(bus_response),
        .bus_waitrequest(bus_waitrequest), .dbg_state(dbg_state)
    );

    bus_initiator #(.TIMEOUT_CYCLES(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(nt_cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(nt_rsp_valid), .rsp_ready(nt_rsp_ready), .rsp_rdata(nt_rsp_rdata),
        .rsp_status(nt_rsp_status), .rsp_timeout(nt_rsp_timeout),
        .bus_addr(nt_bus_addr), .bus_read(nt_bus_read), .bus_write(nt_bus_write),
        .bus_writedata(nt_bus_writedata), .bus_byteenable(nt_bus_byteenable),
        .bus_readdata(bus_readdata), .bus_response(bus_response),
        .bus_waitrequest(nt_waitrequest), .dbg_state(nt_dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [34:0] obs);
        logic [34:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=0x%0h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            last_exp = exp;
            check(tag, {29'h0, obs}, {29'h0, exp});
        end
    endtask

    // Issues one command at a negedge and follows it to the first RESP cycle.
    task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int stalls, input logic [31:0] rdata, input logic [1:0] resp);
        int exp_strobes;
        int strobes;
        if (stalls >= TMO) begin
            exp_q.push_back({1'b1, RESP_DECERR, 32'h0});
            exp_strobes = TMO;
        end else begin
            exp_q.push_back({1'b0, resp, wr ? 32'h0 : rdata});
            exp_strobes = stalls + 1;
        end
        check({tag, "_cmd_ready"}, {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        bus_readdata = rdata; bus_response = resp; bus_waitrequest = (stalls > 0);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_be = ~be;
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            if (!(bus_read || bus_write)) break;
            check({tag, "_strobe"}, {62'h0, bus_read, bus_write}, {62'h0, !wr, wr});
            check({tag, "_addr"}, {32'h0, bus_addr}, {32'h0, addr});
            check({tag, "_wdata_be"}, {28'h0, bus_byteenable, bus_writedata}, {28'h0, be, wdata});
            check({tag, "_busy_ready"}, {63'h0, cmd_ready}, 64'h0);
            strobes++;
            bus_waitrequest = (k < stalls);
            @(negedge clk);
        end
        bus_waitrequest = 1'b0;
        check({tag, "_strobe_cycles"}, 64'(strobes), 64'(exp_strobes));
        check({tag, "_rsp_valid"}, {63'h0, rsp_valid}, 64'h1);
        pop_check({tag, "_rsp"}, {rsp_timeout, rsp_status, rsp_rdata});
    endtask

    // Holds rsp_ready low for hold cycles, then completes the handshake.
    task automatic rsp_handshake(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_rsp"}, {28'h0, rsp_valid, rsp_timeout, rsp_status, rsp_rdata},
                  {28'h0, 1'b1, last_exp});
            check({tag, "_hold_idle_bus"}, {61'h0, cmd_ready, bus_read, bus_write}, 64'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check({tag, "_after_hs"}, {60'h0, rsp_valid, cmd_ready, bus_read, bus_write}, 64'h4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'h0, cmd_ready, rsp_valid, bus_read, bus_write, rsp_timeout, dbg_state == ST_IDLE},
              64'h1);
        check("reset_bus_addr", {32'h0, bus_addr}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {62'h0, cmd_ready, nt_cmd_ready}, 64'h3);

        // Zero-wait read: strobe in N+1, response in N+2
        run_xfer("rd_fast", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, RESP_OKAY);
        rsp_handshake("rd_fast", 0);

        // Write with three stall cycles
        run_xfer("wr_stall", 1'b1, 32'h0000_0104, 32'h1234_5678, 4'hF, 3, 32'hAAAA_5555, RESP_OKAY);
        rsp_handshake("wr_stall", 0);

        // Waitrequest stuck high: timeout
        run_xfer("rd_tmo", 1'b0, 32'h0000_0200, 32'h0, 4'h3, 100, 32'hFFFF_FFFF, RESP_OKAY);
        rsp_handshake("rd_tmo", 0);

        // Waitrequest falls in the limit cycle: completion wins
        run_xfer("rd_edge", 1'b0, 32'h0000_0300, 32'h0, 4'hC, TMO - 1, 32'h0BAD_F00D, RESP_SLVERR);
        rsp_handshake("rd_edge", 0);

        // Unmapped address returns zero data with OKAY
        run_xfer("rd_unmapped", 1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 32'h0, RESP_OKAY);
        rsp_handshake("rd_unmapped", 0);

        // Back-pressure on the response with a new command waiting
        run_xfer("bp", 1'b1, 32'h0000_0010, 32'hCAFE_0001, 4'h1, 1, 32'h0, RESP_DECERR);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0999;
        rsp_handshake("bp", 5);

        // Reset mid-transfer
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0500; bus_waitrequest = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_strobe_before", {63'h0, bus_read}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobe_drop", {60'h0, bus_read, bus_write, rsp_valid, cmd_ready}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_clean_idle", {59'h0, rsp_valid, bus_read, bus_write, cmd_ready, dbg_state == ST_IDLE},
                  64'h3);
        end
        check("rst_mid_addr_cleared", {32'h0, bus_addr}, 64'h0);

        // Timeout disabled: wait indefinitely
        cmd_write = 1'b0; cmd_addr = 32'h0000_0600; bus_readdata = 32'h5A5A_1234;
        bus_response = RESP_OKAY; nt_waitrequest = 1'b1; nt_cmd_valid = 1'b1;
        exp_q.push_back({1'b0, RESP_OKAY, 32'h5A5A_1234});
        @(negedge clk);
        nt_cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("nt_still_waiting", {62'h0, nt_bus_read, nt_rsp_valid}, 64'h2);
        nt_waitrequest = 1'b0;
        @(negedge clk);
        check("nt_rsp_valid", {63'h0, nt_rsp_valid}, 64'h1);
        pop_check("nt_rsp", {nt_rsp_timeout, nt_rsp_status, nt_rsp_rdata});
        nt_rsp_ready = 1'b1;
        @(negedge clk);
        nt_rsp_ready = 1'b0;
        check("nt_back_idle", {62'h0, nt_rsp_valid, nt_cmd_ready}, 64'h1);

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
